// File: rtl/weighted_burst_scheduler.sv
// weighted_burst_scheduler
//   Shares one downstream sink between CLIENTS source FIFOs. Each grant tenure
//   lets the owner move up to weight[i] beats, then the next owner is chosen
//   round-robin starting just after the previous owner. Sink backpressure and
//   the pause throttle stall beats without ending the tenure.
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   req          per-client "source FIFO not empty"
//   weight       per-client max beats per tenure, client i at [i*WEIGHT_W +: WEIGHT_W]; 0 disables
//   pause        blocks beats and tenure starts
//   sink_ready   sink accepts a beat this cycle
//   gnt          one-hot beat strobe (owner FIFO read enable)
//   gnt_valid    |gnt (sink write enable)
//   gnt_id       current owner index (registered), valid while busy
//   burst_last   current beat is the final beat of the tenure
//   busy         a tenure is active (registered)
module weighted_burst_scheduler #(
  parameter int unsigned CLIENTS  = 4,
  parameter int unsigned WEIGHT_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CLIENTS-1:0]            req,
  input  logic [CLIENTS*WEIGHT_W-1:0]   weight,
  input  logic                          pause,
  input  logic                          sink_ready,
  output logic [CLIENTS-1:0]            gnt,
  output logic                          gnt_valid,
  output logic [$clog2(CLIENTS)-1:0]    gnt_id,
  output logic                          burst_last,
  output logic                          busy
);

  localparam int unsigned ID_W = $clog2(CLIENTS);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;

  logic [CLIENTS-1:0]  eligible;
  logic                any_elig;
  logic                beat;
  logic                rel;
  logic [ID_W-1:0]     owner_next;
  logic [ID_W-1:0]     base;
  logic [ID_W-1:0]     pick;
  logic [WEIGHT_W-1:0] pick_w;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < CLIENTS; i++) begin
      eligible[i] = req[i] && (weight[i*WEIGHT_W +: WEIGHT_W] != '0);
    end
  end

  assign any_elig   = |eligible;
  assign owner_next = (owner_q == ID_W'(CLIENTS - 1)) ? '0 : owner_q + ID_W'(1);

  assign beat = (state_q == BURST) && req[owner_q] && sink_ready && !pause;

  // Pause freezes the whole tenure, including an early-drain release; the
  // release is taken once pause drops, so a re-pick is never blocked here.
  assign rel  = (state_q == BURST) && !pause &&
                ((beat && cnt_q == WEIGHT_W'(1)) || !req[owner_q]);

  // On release the search starts just past the old owner, so the releasing
  // client is looked at last and the next tenure can start with no bubble.
  assign base = rel ? owner_next : ptr_q;

  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] idx_s;
    logic            found;
    pick   = '0;
    pick_w = '0;
    found  = 1'b0;
    idx    = 0;
    idx_s  = '0;
    for (int unsigned k = 0; k < CLIENTS; k++) begin
      idx   = (32'(base) + k) % CLIENTS;
      idx_s = ID_W'(idx);
      if (!found && eligible[idx_s]) begin
        found  = 1'b1;
        pick   = idx_s;
        pick_w = weight[idx_s*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (any_elig && !pause) begin
          state_d = BURST;
          owner_d = pick;
          cnt_d   = pick_w;
        end
      end
      BURST: begin
        if (rel) begin
          ptr_d = owner_next;
          if (any_elig) begin
            owner_d = pick;
            cnt_d   = pick_w;
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          cnt_d = cnt_q - WEIGHT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt        = beat ? (CLIENTS'(1) << owner_q) : '0;
  assign gnt_valid  = beat;
  assign burst_last = beat && (cnt_q == WEIGHT_W'(1));
  assign gnt_id     = owner_q;
  assign busy       = (state_q == BURST);

endmodule
